// File: rtl/pcpi_dot4_unit.sv
// PCPI coprocessor: 4-lane unsigned 8-bit dot product, one lane per cycle; ready 5 cycles after accept (ACCCLR: 1).
// Host holds pcpi_valid until pcpi_ready; dropping it mid-run aborts. Optional accumulator under PCPI_DOT4_ACC_EN.
module pcpi_dot4_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      r_state;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [17:0] r_sum;
    logic [1:0]  r_lane;
    logic        r_wait;
    logic        r_ready;
    logic        r_wr;
    logic [31:0] r_rd;

    logic        w_base;
    logic        w_is_dotp;
    logic        w_match;
    logic [15:0] w_prod;
    logic [17:0] w_sum_next;
    logic [31:0] w_dot32;

    assign w_base    = (pcpi_insn[6:0] == 7'b0001011) && (pcpi_insn[31:25] == 7'b0000001);
    assign w_is_dotp = w_base && (pcpi_insn[14:12] == 3'b000);

`ifdef PCPI_DOT4_ACC_EN
    logic [31:0] r_acc;
    logic        r_accum;
    logic        w_is_dotpa;
    logic        w_is_clr;
    logic [31:0] w_acc_next;

    assign w_is_dotpa = w_base && (pcpi_insn[14:12] == 3'b001);
    assign w_is_clr   = w_base && (pcpi_insn[14:12] == 3'b010);
    assign w_match    = w_is_dotp || w_is_dotpa || w_is_clr;
    assign w_acc_next = r_acc + w_dot32;
`else
    assign w_match    = w_is_dotp;
`endif

    // Operands shift right one lane per step, so lane i is always in the low byte.
    assign w_prod     = r_a[7:0] * r_b[7:0];
    assign w_sum_next = r_sum + {2'b00, w_prod};
    assign w_dot32    = {14'b0, w_sum_next};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_lane  <= '0;
            r_wait  <= 1'b0;
            r_ready <= 1'b0;
            r_wr    <= 1'b0;
            r_rd    <= '0;
`ifdef PCPI_DOT4_ACC_EN
            r_acc   <= '0;
            r_accum <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (pcpi_valid && w_match) begin
`ifdef PCPI_DOT4_ACC_EN
                        if (w_is_clr) begin
                            r_acc   <= '0;
                            r_rd    <= '0;
                            r_ready <= 1'b1;
                            r_wr    <= 1'b1;
                            r_state <= S_DONE;
                        end else
`endif
                        begin
                            r_a     <= pcpi_rs1;
                            r_b     <= pcpi_rs2;
                            r_sum   <= '0;
                            r_lane  <= '0;
                            r_wait  <= 1'b1;
                            r_state <= S_RUN;
`ifdef PCPI_DOT4_ACC_EN
                            r_accum <= w_is_dotpa;
`endif
                        end
                    end
                end
                S_RUN: begin
                    if (!pcpi_valid) begin
                        r_wait  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_sum  <= w_sum_next;
                        r_a    <= r_a >> 8;
                        r_b    <= r_b >> 8;
                        r_lane <= r_lane + 2'd1;
                        if (r_lane == 2'd3) begin
                            r_wait  <= 1'b0;
                            r_ready <= 1'b1;
                            r_wr    <= 1'b1;
                            r_state <= S_DONE;
`ifdef PCPI_DOT4_ACC_EN
                            if (r_accum) begin
                                r_acc <= w_acc_next;
                                r_rd  <= w_acc_next;
                            end else begin
                                r_rd  <= w_dot32;
                            end
`else
                            r_rd <= w_dot32;
`endif
                        end
                    end
                end
                S_DONE: begin
                    // Leaving DONE never accepts, even with pcpi_valid still high.
                    r_ready <= 1'b0;
                    r_wr    <= 1'b0;
                    r_rd    <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pcpi_wait  = r_wait;
    assign pcpi_ready = r_ready;
    assign pcpi_wr    = r_wr;
    assign pcpi_rd    = r_rd;

endmodule

// File: doc/pcpi_dot4_unit.md
PCPI_DOT4_UNIT -- requirements
Module: pcpi_dot4_unit

Interface
REQ-001 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: pcpi_valid  input  1  host requests execution of pcpi_insn; held until pcpi_ready.
REQ-004 SHALL have port: pcpi_insn  input  32  instruction word from the nibble-serial instruction loader.
REQ-005 SHALL have port: pcpi_rs1  input  32  operand A; four unsigned 8-bit lanes, lane0 = [7:0].
REQ-006 SHALL have port: pcpi_rs2  input  32  operand B; same lane layout as pcpi_rs1.
REQ-007 SHALL have port: pcpi_wr  output  1  result valid for write-back; high only while pcpi_ready is high.
REQ-008 SHALL have port: pcpi_rd  output  32  result; zero whenever pcpi_ready is low.
REQ-009 SHALL have port: pcpi_wait  output  1  unit has accepted the instruction and is busy.
REQ-010 SHALL have port: pcpi_ready  output  1  single-cycle completion strobe.

Function
REQ-011 SHALL match only if insn[6:0]=7'b0001011, insn[31:25]=7'b0000001, and insn[14:12] is a supported funct3.
REQ-012 SHALL support funct3 000 DOTP: rd = zero-extended sum over lanes i=0..3 of A_i*B_i.
REQ-013 SHALL use a 16-bit product per lane and an 18-bit sum; max result 0x3F804, never overflows.
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; all outputs registered.
REQ-015 SHALL, in IDLE, on an edge sampling pcpi_valid=1 with a match: latch rs1/rs2, clear sum, lane counter=0, go RUN, set pcpi_wait=1.
REQ-016 SHALL, in RUN, add one lane product per edge (lane 0 first); on the edge adding lane 3, go DONE.
REQ-017 SHALL, in DONE, drive pcpi_ready=1, pcpi_wr=1, pcpi_rd=result, pcpi_wait=0 for exactly one cycle, then return to IDLE.
REQ-018 SHALL present pcpi_ready in the 5th cycle after the accepting edge for DOTP.
REQ-019 SHALL NOT accept a new instruction on the edge leaving DONE, even if pcpi_valid is still high.
REQ-020 SHALL, for a non-matching instruction, leave pcpi_wait, pcpi_ready, pcpi_wr low indefinitely.
REQ-021 SHALL abort on pcpi_valid=0 sampled in RUN: return to IDLE, pcpi_wait=0, no ready pulse.
REQ-022 SHALL ignore changes on rs1/rs2/insn after acceptance.

Reset
REQ-023 SHALL, on an edge with rst_n=0, enter IDLE and set pcpi_wait=0, pcpi_ready=0, pcpi_wr=0, pcpi_rd=0, sum=0, lane counter=0.
REQ-024 SHALL, on reset mid-RUN or in DONE, discard the operation with no ready pulse.
REQ-025 SHALL clear the accumulator (REQ-027) on reset.

Configuration
REQ-026 SHALL compile the accumulator feature only when macro PCPI_DOT4_ACC_EN is defined.
REQ-027 SHALL, with PCPI_DOT4_ACC_EN: hold a 32-bit accumulator; funct3 001 DOTPA does acc = acc + dot mod 2^32, rd = new acc, same timing as DOTP.
REQ-028 SHALL, with PCPI_DOT4_ACC_EN: funct3 010 ACCCLR sets acc=0, rd=0, goes IDLE->DONE directly, ready in the 1st cycle after acceptance.
REQ-029 SHALL, without PCPI_DOT4_ACC_EN: treat funct3 001/010 as non-matching (REQ-020); no accumulator storage.

Verification
REQ-030 DOTP, rs1=0x04030201, rs2=0x08070605 -> pcpi_wait next cycle, pcpi_ready/pcpi_wr one cycle in 5th cycle, pcpi_rd=0x00000046.
REQ-031 DOTP, rs1=rs2=0xFFFFFFFF -> pcpi_rd=0x0003F804.
REQ-032 insn opcode 7'b0110011 held valid 20 cycles -> pcpi_wait, pcpi_ready, pcpi_wr stay 0, pcpi_rd=0.
REQ-033 DOTP accepted, pcpi_valid dropped 2 cycles later -> no ready pulse; next DOTP gives correct result; rst_n=0 mid-RUN -> all outputs 0 next cycle.
REQ-034 With PCPI_DOT4_ACC_EN: DOTPA twice on REQ-030 operands -> rd 0x46 then 0x8C; ACCCLR -> rd 0, ready in 1st cycle; next DOTPA -> 0x46.
REQ-035 Without PCPI_DOT4_ACC_EN: DOTPA and ACCCLR -> no wait/ready for 20 cycles.
